cash_dispenser: RTL and testbench
=================================

Name: cash_dispenser

Overview:
Downstream stage of the ATM transaction controller. Accepts an approved withdrawal amount and plans a greedy split into four note denominations against a per-denomination inventory. It then drives the note-feed mechanism one note at a time over a valid/ack handshake. It reports completion, or rejects the request without dispensing anything when the amount cannot be paid exactly.

Parameters:
DEN3, 20000, value of denomination code 3 (largest)
DEN2, 10000, value of denomination code 2
DEN1, 5000, value of denomination code 1
DEN0, 1000, value of denomination code 0 (smallest)
CNT_W, 16, width of inventory and plan counters
AMT_W, 32, width of requested amount

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
load_stb  in  1  write load_count into inventory[load_sel]
load_sel  in  2  denomination code for load
load_count  in  CNT_W  new inventory count
dispense_req  in  1  one-cycle request strobe; amount is sampled with it
amount  in  AMT_W  withdrawal amount, in the same units as DENx
busy  out  1  high whenever the FSM is not in IDLE
bill_valid  out  1  a note is presented to the mechanism
bill_den  out  2  denomination code of the presented note
bill_ack  in  1  mechanism accepted the presented note
done  out  1  one-cycle pulse: dispense finished
no_cash  out  1  one-cycle pulse: request rejected
inv3, inv2, inv1, inv0  out  CNT_W each  current inventory per denomination

Behaviour:
- Reset (clock, reset: synchronous, active-high):
  - FSM goes to IDLE.
  - All outputs are 0: busy, bill_valid, bill_den, done, no_cash, inv0..inv3.
  - Plan counters and the remainder register are cleared.
  - Reset mid-operation aborts immediately; notes already acked are not restored.
- All outputs are registered.
- FSM states: IDLE, PLAN, DISPENSE, DONE, FAIL.
- IDLE:
  - load_stb writes inventory[load_sel] <= load_count.
  - dispense_req captures amount into rem, sets den index d=3, clears plan counters, and moves to PLAN next cycle; busy=1 from that cycle.
  - load_stb and dispense_req in the same cycle: both take effect, and the plan sees the loaded value.
- load_stb and dispense_req are ignored in every state except IDLE.
- PLAN (one decision per cycle):
  - If rem >= DEN[d] and inventory[d] - plan[d] > 0: plan[d]++ and rem -= DEN[d].
  - Else if d > 0: d--.
  - Else (d == 0, no take): go to DISPENSE if rem == 0, otherwise go to FAIL.
- DISPENSE:
  - Presents the highest code with plan[d] != 0: bill_valid=1, bill_den=d.
  - bill_valid and bill_den hold stable until bill_ack.
  - On a cycle with bill_valid && bill_ack: inventory[d]-- and plan[d]--.
  - The next note is presented on the following cycle; there are no bubble cycles required.
  - bill_ack while bill_valid=0 is ignored.
  - When all plan counters are 0, bill_valid drops and the FSM enters DONE.
- DONE: done=1 for one cycle, then IDLE, with busy=0 on the following cycle.
- FAIL: no_cash=1 for one cycle, then IDLE. Inventory is unchanged and no note is presented.
- amount == 0: PLAN walks d down to 0 with no takes, then DISPENSE with zero notes, then DONE. No bill_valid is asserted.
- Arithmetic:
  - rem is AMT_W bits; comparisons are unsigned.
  - Inventory never underflows; a note is only planned when available.
- Note order: always non-increasing denomination code.

Test Plan:
1. Load all four inventories = 5; amount = 36000 -> notes with codes 3, 2, 1, 0, one each; done pulses one cycle after the last ack; inv3..inv0 = 4, 4, 4, 4.
2. Inventories = 5 each; amount = 1500 -> no_cash pulses once, bill_valid never asserts, inventories remain 5.
3. inv3=1, inv2=0, inv1=10, inv0=0; amount = 40000 -> notes 3, 1, 1, 1, 1; then done; inv3=0, inv1=6.
4. During DISPENSE, hold bill_ack=0 for 10 cycles -> bill_valid=1 and bill_den stay constant, inventory unchanged; assert ack -> only that denomination decrements, by exactly 1.
5. Assert reset after 2 of 4 notes are acked -> the next cycle shows busy=0, bill_valid=0, done=0, and inv0..inv3=0.
6. Pulse dispense_req with amount=20000 while busy -> ignored, and the original transaction completes unchanged; amount=0 in IDLE -> done pulse with zero notes.

Source files
------------

// File: rtl/cash_dispenser.sv
// Note dispenser: greedy split of a withdrawal into four denominations against
// a per-denomination inventory, then one note at a time over valid/ack.
module cash_dispenser #(
    parameter int unsigned DEN3  = 20000,
    parameter int unsigned DEN2  = 10000,
    parameter int unsigned DEN1  = 5000,
    parameter int unsigned DEN0  = 1000,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned AMT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_stb,
    input  logic [1:0]       load_sel,
    input  logic [CNT_W-1:0] load_count,
    input  logic             dispense_req,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             bill_valid,
    output logic [1:0]       bill_den,
    input  logic             bill_ack,
    output logic             done,
    output logic             no_cash,
    output logic [CNT_W-1:0] inv3,
    output logic [CNT_W-1:0] inv2,
    output logic [CNT_W-1:0] inv1,
    output logic [CNT_W-1:0] inv0
);

    typedef enum logic [2:0] {
        IDLE,
        PLAN,
        DISPENSE,
        DONE,
        FAIL
    } state_t;

    state_t state, state_n;

    logic [3:0][CNT_W-1:0] inv_q, inv_n;
    logic [3:0][CNT_W-1:0] plan_q, plan_n;
    logic [AMT_W-1:0]      rem_q, rem_n;
    logic [1:0]            d_q, d_n;

    logic                  busy_n, bill_valid_n, done_n, no_cash_n;
    logic [1:0]            bill_den_n;
    logic [AMT_W-1:0]      den_cur;
    logic                  take;

    // Value of a denomination code in amount units.
    function automatic logic [AMT_W-1:0] den_of(input logic [1:0] code);
        case (code)
            2'd3:    den_of = AMT_W'(DEN3);
            2'd2:    den_of = AMT_W'(DEN2);
            2'd1:    den_of = AMT_W'(DEN1);
            default: den_of = AMT_W'(DEN0);
        endcase
    endfunction

    assign den_cur = den_of(d_q);
    assign take    = (rem_q >= den_cur) && (inv_q[d_q] > plan_q[d_q]);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_n      = state;
        inv_n        = inv_q;
        plan_n       = plan_q;
        rem_n        = rem_q;
        d_n          = d_q;
        busy_n       = 1'b0;
        bill_valid_n = 1'b0;
        bill_den_n   = 2'd0;
        done_n       = 1'b0;
        no_cash_n    = 1'b0;

        case (state)
            IDLE: begin
                if (load_stb) begin
                    inv_n[load_sel] = load_count;
                end
                if (dispense_req) begin
                    rem_n   = amount;
                    d_n     = 2'd3;
                    plan_n  = '0;
                    state_n = PLAN;
                end
            end
            PLAN: begin
                if (take) begin
                    plan_n[d_q] = plan_q[d_q] + CNT_W'(1);
                    rem_n       = rem_q - den_cur;
                end else if (d_q != 2'd0) begin
                    d_n = d_q - 2'd1;
                end else if (rem_q == '0) begin
                    state_n = DISPENSE;
                end else begin
                    plan_n  = '0;
                    state_n = FAIL;
                end
            end
            DISPENSE: begin
                if (bill_valid && bill_ack) begin
                    inv_n[bill_den]  = inv_q[bill_den] - CNT_W'(1);
                    plan_n[bill_den] = plan_q[bill_den] - CNT_W'(1);
                end
                if (plan_n == '0) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            FAIL: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs reflect the state being entered so they register in step with it.
        busy_n       = (state_n != IDLE);
        done_n       = (state_n == DONE);
        no_cash_n    = (state_n == FAIL);
        bill_valid_n = (state_n == DISPENSE) && (plan_n != '0);
        if (bill_valid_n) begin
            if (plan_n[3] != '0) begin
                bill_den_n = 2'd3;
            end else if (plan_n[2] != '0) begin
                bill_den_n = 2'd2;
            end else if (plan_n[1] != '0) begin
                bill_den_n = 2'd1;
            end else begin
                bill_den_n = 2'd0;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            inv_q      <= '0;
            plan_q     <= '0;
            rem_q      <= '0;
            d_q        <= 2'd0;
            busy       <= 1'b0;
            bill_valid <= 1'b0;
            bill_den   <= 2'd0;
            done       <= 1'b0;
            no_cash    <= 1'b0;
        end else begin
            inv_q      <= inv_n;
            plan_q     <= plan_n;
            rem_q      <= rem_n;
            d_q        <= d_n;
            busy       <= busy_n;
            bill_valid <= bill_valid_n;
            bill_den   <= bill_den_n;
            done       <= done_n;
            no_cash    <= no_cash_n;
        end
    end

    assign inv3 = inv_q[3];
    assign inv2 = inv_q[2];
    assign inv1 = inv_q[1];
    assign inv0 = inv_q[0];

endmodule

// File: tb/tb_cash_dispenser.sv
// Bench for cash_dispenser: transaction-level model (greedy split into a note
// queue) compared against the DUT every cycle, plus literal end-of-test checks.
module tb_cash_dispenser;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_stb;
    logic [1:0]  load_sel;
    logic [15:0] load_count;
    logic        dispense_req;
    logic [31:0] amount;
    logic        busy, bill_valid, done, no_cash, bill_ack;
    logic [1:0]  bill_den;
    logic [15:0] inv3, inv2, inv1, inv0;

    int checks = 0;
    int errors = 0;

    cash_dispenser dut (
        .clock(clock), .reset(reset),
        .load_stb(load_stb), .load_sel(load_sel), .load_count(load_count),
        .dispense_req(dispense_req), .amount(amount),
        .busy(busy), .bill_valid(bill_valid), .bill_den(bill_den), .bill_ack(bill_ack),
        .done(done), .no_cash(no_cash),
        .inv3(inv3), .inv2(inv2), .inv1(inv1), .inv0(inv0)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phases 0 idle, 1 planning, 2 dispensing, 3 done, 4 rejected.
    longint den_val [4] = '{1000, 5000, 10000, 20000};
    int     m_phase = 0;
    int     m_plan_cycles = 0;
    bit     m_ok = 0;
    int     m_inv [4] = '{0, 0, 0, 0};
    int     m_q [$];
    bit     cmp_en = 0;

    always begin
        @(posedge clock);
        if (reset) begin
            m_phase = 0;
            m_q.delete();
            for (int i = 0; i < 4; i++) m_inv[i] = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (load_stb) m_inv[load_sel] = int'(load_count);
                    if (dispense_req) begin
                        longint rem;
                        int takes;
                        rem = longint'(amount);
                        takes = 0;
                        m_q.delete();
                        for (int d = 3; d >= 0; d--) begin
                            longint n;
                            n = rem / den_val[d];
                            if (n > m_inv[d]) n = m_inv[d];
                            for (int k = 0; k < n; k++) m_q.push_back(d);
                            takes += int'(n);
                            rem -= n * den_val[d];
                        end
                        m_ok = (rem == 0);
                        if (!m_ok) m_q.delete();
                        // one cycle per take, three code steps, one final decision
                        m_plan_cycles = takes + 4;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_plan_cycles--;
                    if (m_plan_cycles == 0) m_phase = m_ok ? 2 : 4;
                end
                2: begin
                    if (m_q.size() > 0 && bill_ack) begin
                        m_inv[m_q[0]]--;
                        void'(m_q.pop_front());
                    end
                    if (m_q.size() == 0) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("busy",       busy,       m_phase != 0);
            check("bill_valid", bill_valid, (m_phase == 2) && (m_q.size() > 0));
            check("bill_den",   bill_den,   (m_phase == 2 && m_q.size() > 0) ? m_q[0] : 0);
            check("done",       done,       m_phase == 3);
            check("no_cash",    no_cash,    m_phase == 4);
            check("inv3", inv3, m_inv[3]);
            check("inv2", inv2, m_inv[2]);
            check("inv1", inv1, m_inv[1]);
            check("inv0", inv0, m_inv[0]);
        end
    end

    int got [$];

    task automatic load(input logic [1:0] sel, input logic [15:0] cnt);
        load_stb = 1'b1; load_sel = sel; load_count = cnt;
        @(negedge clock);
        load_stb = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] c3, input logic [15:0] c2,
                            input logic [15:0] c1, input logic [15:0] c0);
        load(2'd3, c3); load(2'd2, c2); load(2'd1, c1); load(2'd0, c0);
    endtask

    // Issue a request and play the mechanism; hold = idle cycles before each ack.
    task automatic do_txn(input logic [31:0] amt, input int hold, input bit with_load,
                          input logic [1:0] lsel, input logic [15:0] lcnt, input bit poke,
                          input int stop_after, output bit saw_done, output bit saw_fail);
        int held;
        bit stopped;
        got.delete();
        saw_done = 0; saw_fail = 0; held = 0; stopped = 0;
        dispense_req = 1'b1; amount = amt;
        if (with_load) begin
            load_stb = 1'b1; load_sel = lsel; load_count = lcnt;
        end
        @(negedge clock);
        dispense_req = 1'b0; load_stb = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            dispense_req = poke && (cyc == 2);
            if (poke && cyc == 2) amount = 32'd20000;
            load_stb = poke && (cyc == 3);
            if (poke && cyc == 3) begin load_sel = 2'd3; load_count = 16'd0; end
            if (done) begin saw_done = 1; break; end
            if (no_cash) begin saw_fail = 1; break; end
            bill_ack = 1'b0;
            if (bill_valid) begin
                if (held >= hold) begin
                    bill_ack = 1'b1;
                    got.push_back(int'(bill_den));
                    held = 0;
                end else begin
                    held++;
                end
            end
            @(negedge clock);
            if (stop_after > 0 && got.size() == stop_after) begin stopped = 1; break; end
        end
        bill_ack = 1'b0; dispense_req = 1'b0; load_stb = 1'b0;
        if (!saw_done && !saw_fail && !stopped)
            check("txn_timeout", 0, 1);
        @(negedge clock);
    endtask

    // Compare the accepted note sequence against nibble-packed literal codes.
    task automatic check_notes(input string name, input int n, input logic [31:0] codes);
        check({name, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            check({name, "_code"}, got[i], int'((codes >> (4 * (n - 1 - i))) & 32'h3));
    endtask

    initial begin
        bit sd, sf;
        reset = 1'b1; load_stb = 1'b0; load_sel = 2'd0; load_count = 16'd0;
        dispense_req = 1'b0; amount = 32'd0; bill_ack = 1'b0;
        @(posedge clock);
        cmp_en = 1;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_valid", bill_valid, 0);
        check("rst_done", done, 0);
        check("rst_inv", {inv3, inv2, inv1, inv0}, 0);
        reset = 1'b0;

        // 1: one note of each denomination
        load_all(16'd5, 16'd5, 16'd5, 16'd5);
        do_txn(32'd36000, 0, 0, 2'd0, 16'd0, 0, 0, sd, sf);
        check("t1_done", sd, 1);
        check_notes("t1_notes", 4, 32'h3210);
        check("t1_inv", {inv3, inv2, inv1, inv0}, {16'd4, 16'd4, 16'd4, 16'd4});

        // 2: cannot be paid exactly
        load_all(16'd5, 16'd5, 16'd5, 16'd5);
        do_txn(32'd1500, 0, 0, 2'd0, 16'd0, 0, 0, sd, sf);
        check("t2_fail", sf, 1);
        check("t2_notes", got.size(), 0);
        check("t2_inv", {inv3, inv2, inv1, inv0}, {16'd5, 16'd5, 16'd5, 16'd5});

        // 3: sparse inventory; inv1 loaded in the same cycle as the request
        load(2'd3, 16'd1); load(2'd2, 16'd0); load(2'd1, 16'd0); load(2'd0, 16'd0);
        do_txn(32'd40000, 0, 1, 2'd1, 16'd10, 0, 0, sd, sf);
        check("t3_done", sd, 1);
        check_notes("t3_notes", 5, 32'h31111);
        check("t3_inv3", inv3, 0);
        check("t3_inv1", inv1, 6);

        // 4: mechanism stalls 10 cycles per note
        load_all(16'd5, 16'd5, 16'd5, 16'd5);
        do_txn(32'd30000, 10, 0, 2'd0, 16'd0, 0, 0, sd, sf);
        check("t4_done", sd, 1);
        check_notes("t4_notes", 2, 32'h32);
        check("t4_inv", {inv3, inv2, inv1, inv0}, {16'd4, 16'd4, 16'd5, 16'd5});

        // 5: reset after two of four notes
        load_all(16'd5, 16'd5, 16'd5, 16'd5);
        do_txn(32'd36000, 0, 0, 2'd0, 16'd0, 0, 2, sd, sf);
        check("t5_partial", got.size(), 2);
        reset = 1'b1;
        @(negedge clock);
        check("t5_busy", busy, 0);
        check("t5_valid", bill_valid, 0);
        check("t5_done", done, 0);
        check("t5_inv", {inv3, inv2, inv1, inv0}, 0);
        reset = 1'b0;

        // 6: request and load while busy are ignored; zero amount completes empty
        load_all(16'd5, 16'd5, 16'd5, 16'd5);
        do_txn(32'd20000, 0, 0, 2'd0, 16'd0, 1, 0, sd, sf);
        check("t6_done", sd, 1);
        check_notes("t6_notes", 1, 32'h3);
        check("t6_inv3", inv3, 4);
        do_txn(32'd0, 0, 0, 2'd0, 16'd0, 0, 0, sd, sf);
        check("t6_zero_done", sd, 1);
        check("t6_zero_notes", got.size(), 0);
        check("t6_zero_inv", {inv3, inv2, inv1, inv0}, {16'd4, 16'd5, 16'd5, 16'd5});

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
